// File: rtl/fp_add_unit.sv
// Multi-cycle IEEE-754 single-precision adder/subtractor feeding the FP register-file write port.
// Denormals flush to zero; round-to-nearest-even; fixed ALIGN/ADD/NORM/ROUND sequence.
module fp_add_unit #(
  parameter int unsigned LATENCY = 4,
  parameter logic [31:0] QNAN    = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  dest,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic        invalid,
  output logic        overflow
);

  typedef enum logic [$clog2(LATENCY+1)-1:0] {
    IDLE, ALIGN, ADD, NORM, ROUND
  } state_t;

  state_t      r_state;
  logic [31:0] r_a, r_b;
  logic        r_sx, r_sy, r_zsign, r_zero;
  logic [7:0]  r_ex;
  logic [26:0] r_mx, r_my, r_m;
  logic [27:0] r_sum;
  logic [9:0]  r_e;
  logic        r_spec, r_spec_inv;
  logic [31:0] r_spec_val;

  // ALIGN stage decode
  logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_diff;
  logic [23:0] w_ma, w_mb, w_mx, w_my;
  logic [30:0] w_maga, w_magb;
  logic        w_a_ge, w_sx, w_sy;
  logic [53:0] w_shf;
  logic [26:0] w_my_al;
  logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_spec, w_spec_inv;
  logic [31:0] w_spec_val;

  always_comb begin
    w_ea    = r_a[30:23];
    w_eb    = r_b[30:23];
    w_ma    = (w_ea == 8'd0) ? '0 : {1'b1, r_a[22:0]};
    w_mb    = (w_eb == 8'd0) ? '0 : {1'b1, r_b[22:0]};
    w_maga  = {w_ea, w_ma[22:0]};
    w_magb  = {w_eb, w_mb[22:0]};
    w_a_ge  = (w_maga >= w_magb);
    w_ex    = w_a_ge ? w_ea : w_eb;
    w_ey    = w_a_ge ? w_eb : w_ea;
    w_mx    = w_a_ge ? w_ma : w_mb;
    w_my    = w_a_ge ? w_mb : w_ma;
    w_sx    = w_a_ge ? r_a[31] : r_b[31];
    w_sy    = w_a_ge ? r_b[31] : r_a[31];
    w_diff  = w_ex - w_ey;
    w_shf   = {w_my, 3'b000, 27'd0} >> w_diff;
    // Bits shifted past the round position collapse into the sticky LSB
    w_my_al = (w_diff >= 8'd27) ? {26'd0, |w_my}
                                : {w_shf[53:28], w_shf[27] | (|w_shf[26:0])};
    w_nan_a    = (w_ea == 8'hFF) && (|r_a[22:0]);
    w_nan_b    = (w_eb == 8'hFF) && (|r_b[22:0]);
    w_inf_a    = (w_ea == 8'hFF) && !(|r_a[22:0]);
    w_inf_b    = (w_eb == 8'hFF) && !(|r_b[22:0]);
    w_spec     = w_nan_a | w_nan_b | w_inf_a | w_inf_b;
    w_spec_inv = w_nan_a | w_nan_b | (w_inf_a & w_inf_b & (r_a[31] ^ r_b[31]));
    w_spec_val = w_spec_inv ? QNAN : (w_inf_a ? r_a : r_b);
  end

  // NORM stage: leading-zero count over the non-carry sum
  logic [4:0]  w_lzc;
  logic        w_found;
  logic [26:0] w_nm;
  logic [9:0]  w_ne;

  always_comb begin
    w_lzc   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (!w_found && r_sum[26-i]) begin
        w_lzc   = 5'(i);
        w_found = 1'b1;
      end
    end
    w_nm = r_sum[26:0] << w_lzc;
    w_ne = {2'b00, r_ex} - {5'd0, w_lzc};
  end

  // ROUND stage
  logic        w_rup;
  logic [24:0] w_mr;
  logic [9:0]  w_re;
  logic [22:0] w_frac;

  always_comb begin
    w_rup  = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
    w_mr   = {1'b0, r_m[26:3]} + {24'd0, w_rup};
    w_re   = r_e + {9'd0, w_mr[24]};
    w_frac = w_mr[24] ? w_mr[23:1] : w_mr[22:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_en      <= 1'b0;
      result     <= '0;
      wr_addr    <= '0;
      invalid    <= 1'b0;
      overflow   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_zsign    <= 1'b0;
      r_zero     <= 1'b0;
      r_ex       <= '0;
      r_mx       <= '0;
      r_my       <= '0;
      r_m        <= '0;
      r_sum      <= '0;
      r_e        <= '0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_val <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= {b[31] ^ sub, b[30:0]};
            wr_addr  <= dest;
            invalid  <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            r_state  <= ALIGN;
          end
        end
        ALIGN: begin
          r_sx       <= w_sx;
          r_sy       <= w_sy;
          r_ex       <= w_ex;
          r_mx       <= {w_mx, 3'b000};
          r_my       <= w_my_al;
          r_spec     <= w_spec;
          r_spec_inv <= w_spec_inv;
          r_spec_val <= w_spec_val;
          r_state    <= ADD;
        end
        ADD: begin
          r_sum   <= (r_sx == r_sy) ? ({1'b0, r_mx} + {1'b0, r_my})
                                    : ({1'b0, r_mx} - {1'b0, r_my});
          r_zsign <= r_sx & r_sy;
          r_state <= NORM;
        end
        NORM: begin
          r_zero <= (r_sum == 28'd0);
          if (r_sum[27]) begin
            r_m <= {r_sum[27:2], r_sum[1] | r_sum[0]};
            r_e <= {2'b00, r_ex} + 10'd1;
          end else begin
            r_m <= w_nm;
            r_e <= w_ne;
          end
          r_state <= ROUND;
        end
        ROUND: begin
          if (r_spec) begin
            result  <= r_spec_val;
            invalid <= r_spec_inv;
          end else if (r_zero) begin
            result <= {r_zsign, 31'd0};
          end else if (r_e[9] || (r_e == 10'd0)) begin
            result <= {r_sx, 31'd0};
          end else if (w_re >= 10'd255) begin
            result   <= {r_sx, 8'hFF, 23'd0};
            overflow <= 1'b1;
          end else begin
            result <= {r_sx, w_re[7:0], w_frac};
          end
          done    <= 1'b1;
          wr_en   <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_unit.sv
// Directed bench for fp_add_unit: vector table plus busy, back-to-back and mid-op reset sequences.
module tb_fp_add_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sub;
  logic [31:0] a, b;
  logic [4:0]  dest;
  logic        busy, done, wr_en, invalid, overflow;
  logic [31:0] result;
  logic [4:0]  wr_addr;

  int n_cmp = 0;
  int n_bad = 0;

  fp_add_unit #(.LATENCY(4), .QNAN(32'h7FC00000)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .dest(dest),
    .busy(busy), .done(done), .result(result), .wr_en(wr_en), .wr_addr(wr_addr),
    .invalid(invalid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        inv;
    logic        ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request on the negative edge; returns #1 after the accepting edge with start low.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub, input logic [4:0] idest);
    @(negedge clk);
    a = ia; b = ib; sub = isub; dest = idest; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (bounded); returns the edge count, 99 on timeout.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 12) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!done) cnt = 99;
  endtask

  task automatic run_vec(input int idx);
    int lat;
    string tag;
    tag = $sformatf("vec%0d", idx);
    issue(vecs[idx].a, vecs[idx].b, vecs[idx].sub, vecs[idx].dest);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, ".latency"}, 32'(lat), 32'd4);
    check({tag, ".result"}, result, vecs[idx].res);
    check({tag, ".wr_en"}, 32'(wr_en), 32'd1);
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(vecs[idx].dest));
    check({tag, ".invalid"}, 32'(invalid), 32'(vecs[idx].inv));
    check({tag, ".overflow"}, 32'(overflow), 32'(vecs[idx].ovf));
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, 32'({done, wr_en}), 32'd0);
    check({tag, ".result_hold"}, result, vecs[idx].res);
  endtask

  initial begin
    int lat, pulses;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 5'd4,  32'h40400000, 1'b0, 1'b0};
    vecs[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 5'd5,  32'h40000000, 1'b0, 1'b0};
    vecs[2]  = '{32'h3FC00000, 32'hBFC00000, 1'b0, 5'd6,  32'h00000000, 1'b0, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 5'd7,  32'h3F800000, 1'b0, 1'b0};
    vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 5'd8,  32'h3F800002, 1'b0, 1'b0};
    vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 5'd9,  32'h7FC00000, 1'b1, 1'b0};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd10, 32'h7F800000, 1'b0, 1'b1};
    vecs[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 5'd11, 32'h7FC00000, 1'b1, 1'b0};
    vecs[8]  = '{32'h3F800000, 32'hC0000000, 1'b0, 5'd12, 32'hBF800000, 1'b0, 1'b0};
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 5'd13, 32'h80000000, 1'b0, 1'b0};
    vecs[10] = '{32'h00000001, 32'h3F800000, 1'b0, 5'd14, 32'h3F800000, 1'b0, 1'b0};
    vecs[11] = '{32'h00800000, 32'h00C00000, 1'b1, 5'd15, 32'h80000000, 1'b0, 1'b0};
    vecs[12] = '{32'hFF800000, 32'h3F800000, 1'b1, 5'd31, 32'hFF800000, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; dest = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.outs", {busy, done, wr_en, invalid, overflow, wr_addr}, 32'd0);
    check("reset.result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Start pulses while busy must neither queue nor disturb the operation in flight.
    issue(32'h3F800000, 32'h40000000, 1'b0, 5'd4);
    @(negedge clk);
    a = 32'h40A00000; b = 32'h40A00000; dest = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("busyign.busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("busyign.latency", 32'(lat), 32'd2);
    check("busyign.result", result, 32'h40400000);
    check("busyign.wr_addr", 32'(wr_addr), 32'd4);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (wr_en) pulses++;
    end
    check("busyign.extra_wr", 32'(pulses), 32'd0);

    // Back-to-back: a start raised during the done cycle is accepted on the next edge.
    issue(32'h3F800000, 32'h40000000, 1'b0, 5'd1);
    wait_done(lat);
    check("b2b.first_lat", 32'(lat), 32'd4);
    a = 32'h40400000; b = 32'h3F800000; sub = 1'b1; dest = 5'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b.busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b.gap", 32'(lat + 1), 32'd5);
    check("b2b.result", result, 32'h40000000);
    check("b2b.wr_addr", 32'(wr_addr), 32'd2);

    // Reset at T+2 aborts the operation with no write strobe.
    issue(32'h3F800000, 32'h40000000, 1'b0, 5'd9);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort.outs", 32'({busy, done, wr_en}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wr_en || done) pulses++;
    end
    check("abort.no_wr", 32'(pulses), 32'd0);
    run_vec(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
